// File: rtl/rst_sequencer_if.sv
// Status/control bundle between the reset sequencer and the logic that drives
// its lock and software-reset inputs.
interface rst_sequencer_if #(
    parameter int NUM_STAGES = 3
) ();
    logic                  pll_locked;
    logic                  sw_rst_req;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic                  all_released;
    logic [2:0]            seq_state;

    modport master (
        output pll_locked,
        output sw_rst_req,
        input  stage_rst_n,
        input  all_released,
        input  seq_state
    );

    modport slave (
        input  pll_locked,
        input  sw_rst_req,
        output stage_rst_n,
        output all_released,
        output seq_state
    );
endinterface

// File: rtl/rst_sequencer.sv
// Ordered release of NUM_STAGES active-low reset domains once the PLL is stably
// locked; lock loss or a software request pulls every domain back into reset.
module rst_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int STAGE_DELAY = 16,
    parameter int LOCK_FILTER = 8,
    parameter int SW_RST_HOLD = 32
) (
    input  logic            clk,
    input  logic            rst,
    rst_sequencer_if.slave  bus
);

    // A parameter of 1 still needs a one-bit counter that simply stays at zero.
    localparam int LOCK_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam int DLY_W  = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
    localparam int HOLD_W = (SW_RST_HOLD > 1) ? $clog2(SW_RST_HOLD) : 1;
    localparam int IDX_W  = (NUM_STAGES  > 1) ? $clog2(NUM_STAGES)  : 1;

    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FILTER - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SW_RST_HOLD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_LOCK    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_SWHOLD  = 3'd4
    } state_e;

    state_e                state_q    = ST_RESET;
    state_e                state_d;
    logic [LOCK_W-1:0]     lock_cnt_q = '0;
    logic [LOCK_W-1:0]     lock_cnt_d;
    logic [DLY_W-1:0]      dly_cnt_q  = '0;
    logic [DLY_W-1:0]      dly_cnt_d;
    logic [HOLD_W-1:0]     hold_cnt_q = '0;
    logic [HOLD_W-1:0]     hold_cnt_d;
    logic [IDX_W-1:0]      idx_q      = '0;
    logic [IDX_W-1:0]      idx_d;
    logic [NUM_STAGES-1:0] stage_q    = '0;
    logic [NUM_STAGES-1:0] stage_d;
    logic                  all_q      = 1'b0;
    logic                  all_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RESET;
            lock_cnt_q <= '0;
            dly_cnt_q  <= '0;
            hold_cnt_q <= '0;
            idx_q      <= '0;
            stage_q    <= '0;
            all_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            dly_cnt_q  <= dly_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            idx_q      <= idx_d;
            stage_q    <= stage_d;
            all_q      <= all_d;
        end
    end

    // Software request outranks lock loss, which outranks normal progression.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        dly_cnt_d  = dly_cnt_q;
        hold_cnt_d = hold_cnt_q;
        idx_d      = idx_q;
        stage_d    = stage_q;
        all_d      = all_q;

        unique case (state_q)
            ST_RESET: begin
                state_d    = ST_LOCK;
                lock_cnt_d = '0;
            end

            ST_LOCK: begin
                if (bus.sw_rst_req) begin
                    state_d    = ST_SWHOLD;
                    hold_cnt_d = '0;
                    stage_d    = '0;
                    all_d      = 1'b0;
                end else if (bus.pll_locked) begin
                    if (lock_cnt_q == LOCK_LAST) begin
                        state_d    = ST_RELEASE;
                        lock_cnt_d = '0;
                        dly_cnt_d  = '0;
                        idx_d      = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end else begin
                    lock_cnt_d = '0;
                end
            end

            ST_RELEASE, ST_RUN: begin
                if (bus.sw_rst_req) begin
                    state_d    = ST_SWHOLD;
                    hold_cnt_d = '0;
                    dly_cnt_d  = '0;
                    idx_d      = '0;
                    stage_d    = '0;
                    all_d      = 1'b0;
                end else if (!bus.pll_locked) begin
                    state_d    = ST_LOCK;
                    lock_cnt_d = '0;
                    dly_cnt_d  = '0;
                    idx_d      = '0;
                    stage_d    = '0;
                    all_d      = 1'b0;
                end else if (state_q == ST_RELEASE) begin
                    if (dly_cnt_q == DLY_LAST) begin
                        dly_cnt_d = '0;
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                stage_d[k] = 1'b1;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            all_d   = 1'b1;
                            state_d = ST_RUN;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        dly_cnt_d = dly_cnt_q + 1'b1;
                    end
                end
            end

            ST_SWHOLD: begin
                // A repeated request restarts the hold window from zero.
                if (bus.sw_rst_req) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_LOCK;
                    hold_cnt_d = '0;
                    lock_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d    = ST_RESET;
                lock_cnt_d = '0;
                dly_cnt_d  = '0;
                hold_cnt_d = '0;
                idx_d      = '0;
                stage_d    = '0;
                all_d      = 1'b0;
            end
        endcase
    end

    assign bus.stage_rst_n  = stage_q;
    assign bus.all_released = all_q;
    assign bus.seq_state    = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: an elapsed-time reference model predicts
// each cycle's outputs, and an independent monitor compares them after every edge.
module tb_rst_sequencer;

    localparam int NS   = 3;
    localparam int SD   = 16;
    localparam int LF   = 8;
    localparam int HOLD = 32;

    localparam int P_RESET   = 0;
    localparam int P_LOCK    = 1;
    localparam int P_RELEASE = 2;
    localparam int P_RUN     = 3;
    localparam int P_SWHOLD  = 4;

    typedef struct packed {
        logic [2:0]    st;
        logic          all;
        logic [NS-1:0] stg;
    } obs_t;

    logic clk = 1'b0;
    logic rst;

    rst_sequencer_if #(.NUM_STAGES(NS)) bus ();

    rst_sequencer #(
        .NUM_STAGES (NS),
        .STAGE_DELAY(SD),
        .LOCK_FILTER(LF),
        .SW_RST_HOLD(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    obs_t expQ[$];
    int   assertCount = 0;
    int   failCount   = 0;
    int   edgeNo      = -1;

    // Reference model: phase plus elapsed-cycle counts since each phase began.
    int mPhase      = P_RESET;
    int lockRun     = 0;
    int relElapsed  = 0;
    int holdElapsed = 0;

    function automatic obs_t sample();
        obs_t o;
        o.st  = bus.seq_state;
        o.all = bus.all_released;
        o.stg = bus.stage_rst_n;
        return o;
    endfunction

    function automatic obs_t modelObs();
        obs_t o;
        int released;
        released = (mPhase == P_RELEASE) ? relElapsed / SD :
                   (mPhase == P_RUN)     ? NS : 0;
        o.st  = 3'(mPhase);
        o.all = (released == NS);
        o.stg = NS'((1 << released) - 1);
        return o;
    endfunction

    task automatic modelStep(input logic r, input logic l, input logic s);
        if (r) begin
            mPhase = P_RESET;
        end else begin
            case (mPhase)
                P_RESET: begin
                    mPhase  = P_LOCK;
                    lockRun = 0;
                end
                P_LOCK: begin
                    if (s) begin
                        mPhase = P_SWHOLD; holdElapsed = 0;
                    end else if (l) begin
                        lockRun++;
                        if (lockRun == LF) begin
                            mPhase = P_RELEASE; relElapsed = 0;
                        end
                    end else begin
                        lockRun = 0;
                    end
                end
                P_RELEASE, P_RUN: begin
                    if (s) begin
                        mPhase = P_SWHOLD; holdElapsed = 0;
                    end else if (!l) begin
                        mPhase = P_LOCK; lockRun = 0;
                    end else if (mPhase == P_RELEASE) begin
                        relElapsed++;
                        if (relElapsed == NS * SD) mPhase = P_RUN;
                    end
                end
                default: begin
                    if (s) begin
                        holdElapsed = 0;
                    end else begin
                        holdElapsed++;
                        if (holdElapsed == HOLD) begin
                            mPhase = P_LOCK; lockRun = 0;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: actual state=%0d all=%b stages=%b, required state=%0d all=%b stages=%b",
                     name, act.st, act.all, act.stg, exp.st, exp.all, exp.stg);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic s);
        @(negedge clk);
        rst            = r;
        bus.pll_locked = l;
        bus.sw_rst_req = s;
        modelStep(r, l, s);
        expQ.push_back(modelObs());
        edgeNo = r ? -1 : edgeNo + 1;
    endtask

    task automatic runTo(input int target, input logic l);
        while (edgeNo < target) applyStimulus(1'b0, l, 1'b0);
    endtask

    // Directed check of the edge just driven, against constants from the timing rules.
    task automatic checkNow(input string name, input int st, input logic all, input logic [NS-1:0] stg);
        obs_t e;
        e.st  = 3'(st);
        e.all = all;
        e.stg = stg;
        @(posedge clk);
        #3;
        checkOutput(name, sample(), e);
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("scoreboard", sample(), e);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic r, l, s;
        rst            = 1'b1;
        bus.pll_locked = 1'b0;
        bus.sw_rst_req = 1'b0;
        #1;
        checkOutput("init_values", sample(), '0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);

        $display("[TB] nominal sequence");
        runTo(23, 1'b1); checkNow("nom_e23", P_RELEASE, 1'b0, 3'b000);
        runTo(24, 1'b1); checkNow("nom_e24", P_RELEASE, 1'b0, 3'b001);
        runTo(39, 1'b1); checkNow("nom_e39", P_RELEASE, 1'b0, 3'b001);
        runTo(40, 1'b1); checkNow("nom_e40", P_RELEASE, 1'b0, 3'b011);
        runTo(55, 1'b1); checkNow("nom_e55", P_RELEASE, 1'b0, 3'b011);
        runTo(56, 1'b1); checkNow("nom_e56", P_RUN, 1'b1, 3'b111);

        $display("[TB] reset in the middle of release");
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0);
        runTo(30, 1'b1); checkNow("mid_release_pre", P_RELEASE, 1'b0, 3'b001);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkNow("rst_mid_release", P_RESET, 1'b0, 3'b000);

        $display("[TB] lock filter glitch");
        applyStimulus(1'b0, 1'b1, 1'b0);
        runTo(5, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        runTo(29, 1'b1); checkNow("lockflt_e29", P_RELEASE, 1'b0, 3'b000);
        runTo(30, 1'b1); checkNow("lockflt_e30", P_RELEASE, 1'b0, 3'b001);

        $display("[TB] lock loss in RUN");
        runTo(80, 1'b1); checkNow("run_e80", P_RUN, 1'b1, 3'b111);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkNow("lockloss_run", P_LOCK, 1'b0, 3'b000);
        runTo(136, 1'b1); checkNow("reseq_e136", P_RELEASE, 1'b0, 3'b011);
        runTo(137, 1'b1); checkNow("reseq_e137", P_RUN, 1'b1, 3'b111);

        $display("[TB] software request during release");
        applyStimulus(1'b0, 1'b0, 1'b0);
        runTo(165, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkNow("sw_in_release", P_SWHOLD, 1'b0, 3'b000);
        runTo(197, 1'b1); checkNow("swhold_e197", P_SWHOLD, 1'b0, 3'b000);
        runTo(198, 1'b1); checkNow("swhold_exit", P_LOCK, 1'b0, 3'b000);

        $display("[TB] software hold extension");
        applyStimulus(1'b0, 1'b1, 1'b1);
        runTo(208, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runTo(231, 1'b1); checkNow("swext_e231", P_SWHOLD, 1'b0, 3'b000);
        runTo(240, 1'b1); checkNow("swext_e240", P_SWHOLD, 1'b0, 3'b000);
        runTo(241, 1'b1); checkNow("swext_exit", P_LOCK, 1'b0, 3'b000);

        $display("[TB] same-edge priority");
        runTo(300, 1'b1); checkNow("prio_run", P_RUN, 1'b1, 3'b111);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkNow("prio_sw_over_loss", P_SWHOLD, 1'b0, 3'b000);
        runTo(400, 1'b1); checkNow("prio_run2", P_RUN, 1'b1, 3'b111);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkNow("prio_rst_over_all", P_RESET, 1'b0, 3'b000);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 149) == 0);
            l = ($urandom_range(0, 59) != 0);
            applyStimulus(r, l, s);
        end

        repeat (2) @(posedge clk);
        #3;
        assertCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard_drain: actual pending=%0d, required pending=0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
